// File: rtl/fc_pkg.sv
// Shared definitions for the FC front-end: sequencer state encoding and
// default geometry of the datapath and its buffers.
package fc_pkg;

    localparam int FC_ADDR_W = 12;  // SRAM word-address width
    localparam int FC_WORDS  = 64;  // 64-bit words per neuron (512 bytes)
    localparam int FC_NRN_W  = 8;   // neuron count / index width
    localparam int FC_OUT_W  = 21;  // datapath result width
    localparam int FC_TMO    = 16;  // cycles allowed for fc_cyc_done after the last word

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_FIN   = 3'd4
    } fc_state_t;

endpackage

// File: rtl/fc_addr_gen.sv
// Word/neuron counters and SRAM address generation for the FC sequencer.
// The per-neuron weight and bias bases are kept as running registers so no
// multiplier is needed for nrn*WORDS; all sums wrap modulo 2^ADDR_W.
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int ADDR_W = FC_ADDR_W,
    parameter int WORDS  = FC_WORDS,
    parameter int NRN_W  = FC_NRN_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,       // accepted start: latch config, restart at neuron 0 word 0
    input  logic              inc,        // one word issued this cycle
    input  logic              next,       // advance to the next neuron
    input  logic [NRN_W-1:0]  cfg_nrn,
    input  logic [ADDR_W-1:0] cfg_d_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    output logic [ADDR_W-1:0] d_rd_addr,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic [NRN_W-1:0]  nrn,
    output logic              k_last,     // current word is the last of the neuron
    output logic              nrn_last    // current neuron is the last configured one
);

    localparam int                KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0]     K_LAST = KW'(WORDS - 1);
    localparam logic [KW-1:0]     K_ONE  = 1;
    localparam logic [NRN_W-1:0]  N_ONE  = 1;
    localparam logic [ADDR_W-1:0] A_ONE  = 1;
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(WORDS);

    logic [KW-1:0]     k;
    logic [NRN_W-1:0]  nrn_cnt;
    logic [NRN_W-1:0]  nrn_max;
    logic [ADDR_W-1:0] d_base;
    logic [ADDR_W-1:0] w_nrn_base;
    logic [ADDR_W-1:0] b_nrn_addr;

    // Counters and latched bases; load restarts, next steps to the following neuron.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k          <= '0;
            nrn_cnt    <= '0;
            nrn_max    <= '0;
            d_base     <= '0;
            w_nrn_base <= '0;
            b_nrn_addr <= '0;
        end else if (load) begin
            k          <= '0;
            nrn_cnt    <= '0;
            nrn_max    <= cfg_nrn - N_ONE;
            d_base     <= cfg_d_base;
            w_nrn_base <= cfg_w_base;
            b_nrn_addr <= cfg_b_base;
        end else begin
            if (inc) begin
                k <= k_last ? '0 : k + K_ONE;
            end
            if (next) begin
                k          <= '0;
                nrn_cnt    <= nrn_cnt + N_ONE;
                w_nrn_base <= w_nrn_base + W_STEP;
                b_nrn_addr <= b_nrn_addr + A_ONE;
            end
        end
    end

    assign k_last    = (k == K_LAST);
    assign nrn_last  = (nrn_cnt == nrn_max);
    assign nrn       = nrn_cnt;
    assign d_rd_addr = d_base + ADDR_W'(k);
    assign w_rd_addr = w_nrn_base + ADDR_W'(k);
    assign b_rd_addr = b_nrn_addr;

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the FC front-end datapath. Per neuron it streams WORDS
// feature/weight words, waits for the datapath's cycle-done pulse (bounded
// by TMO cycles) and offers the result on a valid/ready port.
// Handshake: res_valid rises with a captured result and then holds
// res_data/res_idx stable; a transfer happens in a cycle where res_valid and
// res_ready are both high, and res_valid drops on the following cycle.
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int ADDR_W = FC_ADDR_W,
    parameter int WORDS  = FC_WORDS,
    parameter int NRN_W  = FC_NRN_W,
    parameter int OUT_W  = FC_OUT_W,
    parameter int TMO    = FC_TMO
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NRN_W-1:0]  cfg_nrn,
    input  logic [ADDR_W-1:0] cfg_d_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              d_rd_en,
    output logic [ADDR_W-1:0] d_rd_addr,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic              fc_en,
    output logic              fc_clr_n,
    input  logic              fc_cyc_done,
    input  logic [OUT_W-1:0]  fc_final_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [NRN_W-1:0]  res_idx
);

    localparam int            TW       = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TMO - 1);
    localparam logic [TW-1:0] TMR_ONE  = 1;

    fc_state_t        state;
    fc_state_t        state_n;
    logic             ag_load;
    logic             ag_inc;
    logic             ag_next;
    logic             k_last;
    logic             nrn_last;
    logic [NRN_W-1:0] nrn;
    logic [TW-1:0]    tmr;
    logic             start_ok;
    logic             tmo_hit;
    logic             spurious;

    // Abort outranks start, so a start in the abort cycle is not accepted.
    assign start_ok = (state == ST_IDLE) && start && !abort;
    assign tmo_hit  = (state == ST_DRAIN) && !fc_cyc_done && (tmr == TMR_LAST) && !abort;
    assign spurious = fc_cyc_done && (state != ST_DRAIN);

    assign busy      = (state == ST_FEED) || (state == ST_DRAIN) || (state == ST_OUT);
    assign done      = (state == ST_FIN);
    assign d_rd_en   = (state == ST_FEED);
    assign w_rd_en   = (state == ST_FEED);
    assign res_valid = (state == ST_OUT);

    fc_addr_gen #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS),
        .NRN_W  (NRN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rstn       (rstn),
        .load       (ag_load),
        .inc        (ag_inc),
        .next       (ag_next),
        .cfg_nrn    (cfg_nrn),
        .cfg_d_base (cfg_d_base),
        .cfg_w_base (cfg_w_base),
        .cfg_b_base (cfg_b_base),
        .d_rd_addr  (d_rd_addr),
        .w_rd_addr  (w_rd_addr),
        .b_rd_addr  (b_rd_addr),
        .nrn        (nrn),
        .k_last     (k_last),
        .nrn_last   (nrn_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and counter controls; abort overrides everything.
    always_comb begin
        state_n = state;
        ag_load = 1'b0;
        ag_inc  = 1'b0;
        ag_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_nrn != '0) begin
                        state_n = ST_FEED;
                        ag_load = 1'b1;
                    end else begin
                        state_n = ST_FIN;
                    end
                end
            end
            ST_FEED: begin
                ag_inc = 1'b1;
                if (k_last) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fc_cyc_done) begin
                    state_n = ST_OUT;
                end else if (tmr == TMR_LAST) begin
                    state_n = ST_FIN;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    if (nrn_last) begin
                        state_n = ST_FIN;
                    end else begin
                        state_n = ST_FEED;
                        ag_next = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_n = ST_IDLE;
            ag_load = 1'b0;
            ag_inc  = 1'b0;
            ag_next = 1'b0;
        end
    end

    // Drain timer: counts cycles spent waiting for the datapath result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmr <= '0;
        end else if (state != ST_DRAIN) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_ONE;
        end
    end

    // Sticky error: cleared by an accepted start, set by timeout or a stray result pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else begin
            if (start_ok) begin
                err <= 1'b0;
            end
            if (tmo_hit || spurious) begin
                err <= 1'b1;
            end
        end
    end

    // SRAM data arrives one cycle after the read; fc_clr_n flushes the accumulator after abort.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fc_en    <= 1'b0;
            fc_clr_n <= 1'b1;
        end else begin
            fc_en    <= d_rd_en;
            fc_clr_n <= !abort;
        end
    end

    // Result capture on the datapath pulse while draining.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_data <= '0;
            res_idx  <= '0;
        end else if ((state == ST_DRAIN) && fc_cyc_done && !abort) begin
            res_data <= fc_final_out;
            res_idx  <= nrn;
        end
    end

endmodule
